// File: rtl/m_imem_loader.sv
// ============================================================================
// Module   : m_imem_loader
// Brief    : Boot loader filling instruction memory from a byte stream while
//            holding the processor in reset until a checksum-verified load.
// Revision : 1.0
// ============================================================================
`default_nettype none

module m_imem_loader #(
  parameter int ADDR_W    = 12,
  parameter int MAX_WORDS = 4096
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_bvalid,
  input  logic [7:0]        w_bdata,
  output logic              r_bready,
  output logic [ADDR_W-1:0] r_maddr,
  output logic              r_mwe,
  output logic [31:0]       r_mdin,
  output logic              r_prst,
  output logic              r_done,
  output logic              r_err,
  output logic [ADDR_W:0]   r_wcnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR0  = 3'd1,
    S_HDR1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_CSUM  = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  state_t      r_state;
  logic [1:0]  r_bidx;
  logic [7:0]  r_csum;
  logic [15:0] r_nwords;
  logic [23:0] r_word;

  logic            w_take;
  logic [15:0]     w_nhdr;
  logic [ADDR_W:0] w_wcnt_inc;

  assign w_take     = w_bvalid & r_bready;
  assign w_nhdr     = {w_bdata, r_nwords[7:0]};
  assign w_wcnt_inc = r_wcnt + 1'b1;

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_state  <= S_IDLE;
      r_bready <= 1'b0;
      r_maddr  <= '0;
      r_mwe    <= 1'b0;
      r_mdin   <= '0;
      r_prst   <= 1'b1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_wcnt   <= '0;
      r_bidx   <= '0;
      r_csum   <= '0;
      r_nwords <= '0;
      r_word   <= '0;
    end else begin
      r_mwe <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state  <= S_HDR0;
          r_bready <= 1'b1;
        end
        S_HDR0: if (w_take) begin
          r_nwords[7:0] <= w_bdata;
          r_csum        <= r_csum ^ w_bdata;
          r_state       <= S_HDR1;
        end
        S_HDR1: if (w_take) begin
          r_nwords[15:8] <= w_bdata;
          r_csum         <= r_csum ^ w_bdata;
          if (32'(w_nhdr) > MAX_WORDS) begin
            r_state  <= S_ERR;
            r_bready <= 1'b0;
            r_err    <= 1'b1;
          end else if (w_nhdr == '0) begin
            r_state <= S_CSUM;
          end else begin
            r_state <= S_DATA;
          end
        end
        S_DATA: if (w_take) begin
          r_csum <= r_csum ^ w_bdata;
          r_bidx <= r_bidx + 1'b1;
          if (r_bidx == 2'd3) begin
            // Bytes arrive LSB first, so the last byte lands on top.
            r_mdin   <= {w_bdata, r_word};
            r_maddr  <= r_wcnt[ADDR_W-1:0];
            r_mwe    <= 1'b1;
            r_bready <= 1'b0;
            r_state  <= S_WRITE;
          end else begin
            r_word <= {w_bdata, r_word[23:8]};
          end
        end
        S_WRITE: begin
          r_wcnt   <= w_wcnt_inc;
          r_bready <= 1'b1;
          if (32'(w_wcnt_inc) == 32'(r_nwords)) r_state <= S_CSUM;
          else                                   r_state <= S_DATA;
        end
        S_CSUM: if (w_take) begin
          r_bready <= 1'b0;
          if (w_bdata == r_csum) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_prst  <= 1'b0;
          end else begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
          end
        end
        S_DONE, S_ERR: r_bready <= 1'b0;
        default: begin
          r_state  <= S_ERR;
          r_bready <= 1'b0;
          r_err    <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_m_imem_loader.sv
// ============================================================================
// Module   : tb_m_imem_loader
// Brief    : Directed self-checking bench for the instruction-memory loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_m_imem_loader;

  localparam int ADDR_W = 12;

  logic              w_clk;
  logic              w_rst;
  logic              w_bvalid;
  logic [7:0]        w_bdata;
  logic              r_bready;
  logic [ADDR_W-1:0] r_maddr;
  logic              r_mwe;
  logic [31:0]       r_mdin;
  logic              r_prst;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W:0]   r_wcnt;

  int n_vec  = 0;
  int n_fail = 0;

  // write log filled by the monitor
  int          nwr = 0;
  int          wide_mwe = 0;
  logic        prev_mwe = 1'b0;
  logic [ADDR_W-1:0] wr_addr [0:15];
  logic [31:0]       wr_data [0:15];

  m_imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(4096)) dut (
    .w_clk    (w_clk),
    .w_rst    (w_rst),
    .w_bvalid (w_bvalid),
    .w_bdata  (w_bdata),
    .r_bready (r_bready),
    .r_maddr  (r_maddr),
    .r_mwe    (r_mwe),
    .r_mdin   (r_mdin),
    .r_prst   (r_prst),
    .r_done   (r_done),
    .r_err    (r_err),
    .r_wcnt   (r_wcnt)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  always @(negedge w_clk) begin
    if (r_mwe) begin
      if (nwr < 16) begin
        wr_addr[nwr] = r_maddr;
        wr_data[nwr] = r_mdin;
      end
      nwr = nwr + 1;
      if (prev_mwe) wide_mwe = wide_mwe + 1;
    end
    prev_mwe = r_mwe;
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    w_bvalid = 1'b0;
    repeat (gap) @(negedge w_clk);
    w_bvalid = 1'b1;
    w_bdata  = b;
    n = 0;
    while (!r_bready && n < 200) begin
      @(negedge w_clk);
      n++;
    end
    n_vec++;
    if (!r_bready) begin
      $display("FAIL byte_accept_timeout: byte %02h bready=%0b required 1", b, r_bready);
      n_fail++;
    end
    @(negedge w_clk);
    w_bvalid = 1'b0;
  endtask

  task automatic send_case1(input logic [7:0] csum, input int max_gap);
    logic [7:0] s [0:10];
    s = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00};
    s[10] = csum;
    for (int i = 0; i < 11; i++)
      send_byte(s[i], (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0)));
    repeat (2) @(negedge w_clk);
  endtask

  task automatic check_case1_writes(input int base);
    n_vec++;
    if (nwr - base !== 2) begin
      $display("FAIL write_count: got %0d required 2", nwr - base);
      n_fail++;
    end else begin
      n_vec++;
      if (wr_addr[base] !== 12'd0 || wr_data[base] !== 32'h44332211) begin
        $display("FAIL write0: addr=%0d data=%08h required addr=0 data=44332211",
                 wr_addr[base], wr_data[base]);
        n_fail++;
      end
      n_vec++;
      if (wr_addr[base+1] !== 12'd1 || wr_data[base+1] !== 32'h12345678) begin
        $display("FAIL write1: addr=%0d data=%08h required addr=1 data=12345678",
                 wr_addr[base+1], wr_data[base+1]);
        n_fail++;
      end
    end
    n_vec++;
    if (r_wcnt !== 13'd2) begin
      $display("FAIL wcnt: got %0d required 2", r_wcnt);
      n_fail++;
    end
  endtask

  task automatic test_reset;
    @(negedge w_clk);
    w_rst    = 1'b1;
    w_bvalid = 1'b0;
    w_bdata  = 8'h00;
    repeat (2) @(negedge w_clk);
    n_vec++;
    if ({r_bready, r_maddr, r_mwe, r_mdin, r_prst, r_done, r_err, r_wcnt} !==
        {1'b0, 12'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 13'd0}) begin
      $display("FAIL reset_values: bready=%0b maddr=%0d mwe=%0b mdin=%08h prst=%0b done=%0b err=%0b wcnt=%0d required 0 0 0 0 1 0 0 0",
               r_bready, r_maddr, r_mwe, r_mdin, r_prst, r_done, r_err, r_wcnt);
      n_fail++;
    end
    w_rst = 1'b0;
    @(negedge w_clk);
    n_vec++;
    if (r_bready !== 1'b1) begin
      $display("FAIL bready_rise: got %0b required 1 in 2nd cycle after reset", r_bready);
      n_fail++;
    end
  endtask

  task automatic test_good_load;
    int base;
    test_reset();
    base = nwr;
    send_case1(8'h4E, 0);
    check_case1_writes(base);
    n_vec++;
    if ({r_done, r_err, r_prst, r_bready} !== 4'b1000) begin
      $display("FAIL good_status: done=%0b err=%0b prst=%0b bready=%0b required 1 0 0 0",
               r_done, r_err, r_prst, r_bready);
      n_fail++;
    end
  endtask

  task automatic test_empty_load;
    int base;
    test_reset();
    base = nwr;
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    repeat (2) @(negedge w_clk);
    n_vec++;
    if (nwr !== base || r_wcnt !== 13'd0) begin
      $display("FAIL empty_writes: writes=%0d wcnt=%0d required 0 0", nwr - base, r_wcnt);
      n_fail++;
    end
    n_vec++;
    if ({r_done, r_err, r_prst} !== 3'b100) begin
      $display("FAIL empty_status: done=%0b err=%0b prst=%0b required 1 0 0",
               r_done, r_err, r_prst);
      n_fail++;
    end
  endtask

  task automatic test_bad_checksum;
    int base;
    test_reset();
    base = nwr;
    send_case1(8'h4F, 0);
    check_case1_writes(base);
    n_vec++;
    if ({r_done, r_err, r_prst} !== 3'b011) begin
      $display("FAIL badcsum_status: done=%0b err=%0b prst=%0b required 0 1 1",
               r_done, r_err, r_prst);
      n_fail++;
    end
  endtask

  task automatic test_oversize;
    int base;
    int seen_ready;
    test_reset();
    base = nwr;
    send_byte(8'h01, 0);
    send_byte(8'h10, 0);
    n_vec++;
    if ({r_err, r_done, r_bready, r_prst} !== 4'b1001) begin
      $display("FAIL oversize_err: err=%0b done=%0b bready=%0b prst=%0b required 1 0 0 1",
               r_err, r_done, r_bready, r_prst);
      n_fail++;
    end
    seen_ready = 0;
    w_bvalid = 1'b1;
    w_bdata  = 8'hA5;
    repeat (10) begin
      @(negedge w_clk);
      if (r_bready) seen_ready++;
    end
    w_bvalid = 1'b0;
    n_vec++;
    if (seen_ready !== 0 || nwr !== base || r_wcnt !== 13'd0 || r_err !== 1'b1) begin
      $display("FAIL oversize_ignore: ready_cycles=%0d writes=%0d wcnt=%0d err=%0b required 0 0 0 1",
               seen_ready, nwr - base, r_wcnt, r_err);
      n_fail++;
    end
  endtask

  task automatic test_stall_gaps;
    int base;
    int wide0;
    test_reset();
    base  = nwr;
    wide0 = wide_mwe;
    send_case1(8'h4E, 7);
    check_case1_writes(base);
    n_vec++;
    if (wide_mwe !== wide0) begin
      $display("FAIL mwe_width: wide pulses=%0d required 0", wide_mwe - wide0);
      n_fail++;
    end
    n_vec++;
    if ({r_done, r_err, r_prst} !== 3'b100) begin
      $display("FAIL stall_status: done=%0b err=%0b prst=%0b required 1 0 0",
               r_done, r_err, r_prst);
      n_fail++;
    end
  endtask

  task automatic test_midload_reset;
    int base;
    logic [7:0] s [0:7];
    test_reset();
    s = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h78, 8'h56};
    for (int i = 0; i < 8; i++) send_byte(s[i], 0);
    // mid-word: first word written, second word half assembled
    test_reset();
    n_vec++;
    if (r_wcnt !== 13'd0 || r_mdin !== 32'd0) begin
      $display("FAIL midreset_clear: wcnt=%0d mdin=%08h required 0 00000000", r_wcnt, r_mdin);
      n_fail++;
    end
    base = nwr;
    send_case1(8'h4E, 0);
    check_case1_writes(base);
    n_vec++;
    if ({r_done, r_err, r_prst} !== 3'b100) begin
      $display("FAIL midreset_status: done=%0b err=%0b prst=%0b required 1 0 0",
               r_done, r_err, r_prst);
      n_fail++;
    end
  endtask

  initial begin
    w_rst    = 1'b1;
    w_bvalid = 1'b0;
    w_bdata  = 8'h00;
    test_good_load();
    test_empty_load();
    test_bad_checksum();
    test_oversize();
    test_stall_gaps();
    test_midload_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
